// File: rtl/axi_pkg.sv
// Shared AXI encodings, traffic-generator state codes and the data-pattern LFSR step.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef logic [2:0] tg_state_t;

  localparam tg_state_t ST_IDLE = 3'd0;
  localparam tg_state_t ST_AW   = 3'd1;
  localparam tg_state_t ST_W    = 3'd2;
  localparam tg_state_t ST_B    = 3'd3;
  localparam tg_state_t ST_AR   = 3'd4;
  localparam tg_state_t ST_R    = 3'd5;
  localparam tg_state_t ST_DONE = 3'd6;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting toward bit 0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/axi_tg_lfsr.sv
// 32-bit data-pattern LFSR with seed load and advance enable.
module axi_tg_lfsr
  import axi_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_adv,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= 32'h1;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_adv) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/axi_master_traffic_gen.sv
// AXI4 master traffic generator: one write burst, read-back of that burst, LFSR data verify.
// Optional per-state watchdog compiled in with AXI_TG_TIMEOUT_EN.
module axi_master_traffic_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MASTER_ID = 0,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned TO_CYCLES = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [7:0]          cfg_len,
  input  logic [1:0]          cfg_burst,
  input  logic [31:0]         cfg_seed,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_cnt,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready
);

  localparam int unsigned     L_ALIGN_W = $clog2(DATA_W / 8);
  localparam int unsigned     L_REP     = DATA_W / 32;
  localparam logic [ID_W-1:0] L_ID      = ID_W'(MASTER_ID);
  localparam logic [2:0]      L_SIZE    = 3'(L_ALIGN_W);

  if (!(DATA_W == 32 || DATA_W == 64 || DATA_W == 128) ||
      MAX_LEN < 1 || MAX_LEN > 256 || TO_CYCLES < 1) begin : g_param_check
    $error("axi_master_traffic_gen: unsupported parameter set");
  end

  tg_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_beat;
  logic [1:0]        r_burst;
  logic [15:0]       r_err;
  logic [1:0]        w_err_inc;
  logic [16:0]       w_err_sum;
  logic [31:0]       w_seed, w_wlfsr, w_rlfsr;
  logic              w_cfg_bad, w_wrap_ok, w_b_bad, w_rd_bad, w_rlast_bad;
  logic              w_beat_last, w_w_hs, w_r_hs, w_ld;

  assign w_wrap_ok = (cfg_len == 8'd1) || (cfg_len == 8'd3) || (cfg_len == 8'd7) || (cfg_len == 8'd15);
  assign w_cfg_bad = ((cfg_burst == BURST_WRAP) && !w_wrap_ok) ||
                     (({1'b0, cfg_len} + 9'd1) > 9'(MAX_LEN)) ||
                     (cfg_addr[L_ALIGN_W-1:0] != '0);
  assign w_seed    = (cfg_seed == '0) ? 32'h1 : cfg_seed;

  assign w_beat_last = (r_beat == r_len);
  assign w_w_hs      = (r_state == ST_W) && m_wready;
  assign w_r_hs      = (r_state == ST_R) && m_rvalid;
  assign w_b_bad     = (m_bresp != RESP_OKAY) || (m_bid != L_ID);
  assign w_rd_bad    = (m_rdata != {L_REP{w_rlfsr}}) || (m_rresp != RESP_OKAY) || (m_rid != L_ID);
  assign w_rlast_bad = (m_rlast != w_beat_last);

`ifdef AXI_TG_TIMEOUT_EN
  localparam int unsigned      L_TO_W    = $clog2(TO_CYCLES + 1);
  localparam logic [L_TO_W-1:0] L_TO_LAST = L_TO_W'(TO_CYCLES - 1);
  logic [L_TO_W-1:0] r_to_cnt;
  logic              w_hold;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_err_inc   = '0;
    w_ld        = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        if (w_cfg_bad) begin
          w_state_nxt = ST_DONE;
          w_err_inc   = 2'd1;
        end else begin
          w_state_nxt = ST_AW;
          w_ld        = 1'b1;
        end
      end
      ST_AW:   if (m_awready) w_state_nxt = ST_W;
      ST_W:    if (w_w_hs && w_beat_last) w_state_nxt = ST_B;
      ST_B:    if (m_bvalid) begin
        w_state_nxt = ST_AR;
        w_err_inc   = {1'b0, w_b_bad};
      end
      ST_AR:   if (m_arready) w_state_nxt = ST_R;
      ST_R:    if (w_r_hs) begin
        w_err_inc = {1'b0, w_rd_bad} + {1'b0, w_rlast_bad};
        if (m_rlast || w_beat_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
`ifdef AXI_TG_TIMEOUT_EN
    // Beat handshakes count as progress so long healthy bursts in W/R never trip the watchdog.
    w_hold = (w_state_nxt == r_state) && !w_w_hs && !w_r_hs &&
             (r_state != ST_IDLE) && (r_state != ST_DONE);
    if (w_hold && (r_to_cnt == L_TO_LAST)) begin
      w_state_nxt = ST_DONE;
      w_err_inc   = 2'd1;
    end
`endif
  end

  assign w_err_sum = {1'b0, r_err} + {15'd0, w_err_inc};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_sum[16] ? '1 : w_err_sum[15:0];
      if (w_ld) begin
        r_addr  <= cfg_addr;
        r_len   <= cfg_len;
        r_burst <= cfg_burst;
      end
      if ((r_state == ST_AW) || (r_state == ST_AR)) begin
        r_beat <= '0;
      end else if (w_w_hs || w_r_hs) begin
        r_beat <= r_beat + 8'd1;
      end
    end
  end

`ifdef AXI_TG_TIMEOUT_EN
  always_ff @(posedge ACLK) begin
    if (ARESET || !w_hold) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`endif

  axi_tg_lfsr u_wr_lfsr (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_load  (w_ld),
    .i_seed  (w_seed),
    .i_adv   (w_w_hs),
    .o_state (w_wlfsr)
  );

  axi_tg_lfsr u_rd_lfsr (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_load  (w_ld),
    .i_seed  (w_seed),
    .i_adv   (w_r_hs),
    .o_state (w_rlfsr)
  );

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err_cnt   = r_err;

  assign m_awid    = L_ID;
  assign m_awaddr  = r_addr;
  assign m_awlen   = r_len;
  assign m_awsize  = L_SIZE;
  assign m_awburst = r_burst;
  assign m_awvalid = (r_state == ST_AW);

  assign m_wdata   = {L_REP{w_wlfsr}};
  assign m_wstrb   = '1;
  assign m_wlast   = w_beat_last;
  assign m_wvalid  = (r_state == ST_W);

  assign m_bready  = (r_state == ST_B);

  assign m_arid    = L_ID;
  assign m_araddr  = r_addr;
  assign m_arlen   = r_len;
  assign m_arsize  = L_SIZE;
  assign m_arburst = r_burst;
  assign m_arvalid = (r_state == ST_AR);

  assign m_rready  = (r_state == ST_R);

endmodule

// File: tb/tb_axi_master_traffic_gen.sv
// Randomized bench for axi_master_traffic_gen: FIFO-backed AXI slave plus a pass-level reference model.
`timescale 1ns/1ps
module tb_axi_master_traffic_gen;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned MID      = 5;
  localparam int unsigned MAX_LEN  = 16;
  localparam int unsigned TO_CYC   = 64;
  localparam int unsigned EXP_SIZE = $clog2(DATA_W / 8);

  logic                ACLK, ARESET, start;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [7:0]          cfg_len;
  logic [1:0]          cfg_burst;
  logic [31:0]         cfg_seed;
  logic                busy, done;
  logic [15:0]         err_cnt;
  logic [ID_W-1:0]     m_awid, m_arid, m_bid, m_rid;
  logic [ADDR_W-1:0]   m_awaddr, m_araddr;
  logic [7:0]          m_awlen, m_arlen;
  logic [2:0]          m_awsize, m_arsize;
  logic [1:0]          m_awburst, m_arburst, m_bresp, m_rresp;
  logic                m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic                m_bvalid, m_bready, m_arvalid, m_arready;
  logic                m_rlast, m_rvalid, m_rready;
  logic [DATA_W-1:0]   m_wdata, m_rdata;
  logic [DATA_W/8-1:0] m_wstrb;

  axi_master_traffic_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MASTER_ID(MID),
    .MAX_LEN(MAX_LEN), .TO_CYCLES(TO_CYC)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .cfg_burst(cfg_burst), .cfg_seed(cfg_seed), .busy(busy), .done(done), .err_cnt(err_cnt),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_bad = 0;
  int exp_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // x^32 + x^22 + x^2 + x + 1, shifting toward bit 0
  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] taps;
    taps = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  // Slave behaviour knobs, written only by the stimulus process.
  int       k_aw_wait, k_bad_beat, k_bad_kind, k_last_mode, k_early;
  logic [1:0] k_bresp;
  bit       k_bid_bad, k_no_b, k_rand_stall;

  // Slave observations.
  logic [DATA_W-1:0] wq[$];
  bit                wl[$];
  int                aw_hs, ar_hs, aw_vcyc, aw_unstable, bready_cyc, any_act;
  logic [63:0]       aw_pl, ar_pl, aw_first;
  bit                aw_seen, b_pend, r_pend;
  int                r_beat_s, r_len_s;

  task automatic knobs_default;
    k_aw_wait = 0; k_bad_beat = -1; k_bad_kind = 0; k_last_mode = 0; k_early = 0;
    k_bresp = 2'd0; k_bid_bad = 0; k_no_b = 0; k_rand_stall = 0;
  endtask

  initial begin
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
    m_bid = '0; m_bresp = '0; m_rid = '0; m_rdata = '0; m_rresp = '0;
    aw_seen = 0; b_pend = 0; r_pend = 0; r_beat_s = 0; r_len_s = 0;
    forever begin
      tick;
      if (ARESET) begin
        aw_seen = 0; b_pend = 0; r_pend = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
        continue;
      end
      if (m_awvalid || m_wvalid || m_bready || m_arvalid || m_rready) any_act++;
      // B before W so the response only appears after the wlast handshake.
      m_bid   = k_bid_bad ? ID_W'(MID ^ 1) : ID_W'(MID);
      m_bresp = k_bresp;
      m_bvalid = b_pend && !k_no_b;
      if (m_bready) bready_cyc++;
      if (m_bvalid && m_bready) b_pend = 0;
      if (m_wvalid) begin
        m_wready = k_rand_stall ? ($urandom % 3 != 0) : 1'b1;
        if (m_wready) begin
          wq.push_back(m_wdata);
          wl.push_back(m_wlast);
          if (m_wlast) b_pend = 1;
        end
      end else m_wready = 0;
      if (m_awvalid) begin
        if (!aw_seen) begin
          aw_seen = 1;
          aw_first = {15'd0, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid};
          aw_pl = aw_first;
        end
        aw_vcyc++;
        if ({15'd0, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid} !== aw_first) aw_unstable++;
        if (k_aw_wait > 0) begin
          m_awready = 0;
          k_aw_wait--;
        end else begin
          m_awready = 1;
          aw_hs++;
          aw_seen = 0;
        end
      end else m_awready = 0;
      // R before AR so read data starts only once the DUT is in its read phase.
      if (r_pend && !m_rready && !m_arvalid) r_pend = 0;
      m_rvalid = 0;
      if (r_pend && m_rready && (!k_rand_stall || ($urandom % 4 != 0))) begin
        m_rvalid = 1;
        m_rdata  = (r_beat_s < wq.size()) ? wq[r_beat_s] : '0;
        m_rresp  = 2'd0;
        m_rid    = ID_W'(MID);
        if (r_beat_s == k_bad_beat) begin
          if (k_bad_kind == 0 || k_bad_kind == 3) m_rdata = m_rdata ^ DATA_W'(1);
          if (k_bad_kind == 1 || k_bad_kind == 3) m_rresp = 2'd2;
          if (k_bad_kind == 2 || k_bad_kind == 3) m_rid = ID_W'(MID ^ 1);
        end
        case (k_last_mode)
          1:       m_rlast = (r_beat_s == k_early);
          2:       m_rlast = 0;
          default: m_rlast = (r_beat_s == r_len_s);
        endcase
        r_beat_s++;
      end
      if (m_arvalid) begin
        m_arready = k_rand_stall ? 1'($urandom % 2) : 1'b1;
        if (m_arready) begin
          ar_hs++;
          ar_pl = {15'd0, m_araddr, m_arlen, m_arsize, m_arburst, m_arid};
          r_pend = 1; r_beat_s = 0; r_len_s = int'(m_arlen);
        end
      end else m_arready = 0;
    end
  end

  task automatic clear_obs;
    wq.delete(); wl.delete();
    aw_hs = 0; ar_hs = 0; aw_vcyc = 0; aw_unstable = 0; bready_cyc = 0; any_act = 0;
  endtask

  task automatic run_pass(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] seed);
    bit          legal;
    logic [31:0] s;
    logic [63:0] pl;
    int          n_rd, d, cyc;
    legal = !((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) &&
            (int'(len) + 1 <= int'(MAX_LEN)) && (addr % (DATA_W / 8) == 0);
    clear_obs();
    cfg_addr = addr; cfg_len = len; cfg_burst = burst; cfg_seed = seed;
    start = 1; tick; start = 0;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 2000) begin tick; cyc++; end
    chk("done_pulse", done, 1);
    d = 0;
    if (!legal) begin
      d = 1;
      chk("illegal_latency_ok", cyc <= 1, 1);
      chk("illegal_bus_activity", any_act, 0);
    end else begin
      pl = {15'd0, addr, len, 3'(EXP_SIZE), burst, ID_W'(MID)};
      chk("aw_handshakes", aw_hs, 1);
      chk("aw_payload", aw_pl, pl);
      chk("aw_stable", aw_unstable, 0);
      chk("w_beats", wq.size(), int'(len) + 1);
      s = (seed == 0) ? 32'h1 : seed;
      for (int i = 0; i <= int'(len) && i < wq.size(); i++) begin
        chk($sformatf("wdata[%0d]", i), wq[i], {DATA_W/32{s}});
        chk($sformatf("wlast[%0d]", i), wl[i], i == int'(len));
        s = ref_next(s);
      end
      if (k_bresp != 2'd0 || k_bid_bad) d++;
      chk("ar_handshakes", ar_hs, 1);
      chk("ar_payload", ar_pl, pl);
      n_rd = (k_last_mode == 1) ? k_early + 1 : int'(len) + 1;
      if (k_bad_beat >= 0 && k_bad_beat < n_rd) d++;
      if (k_last_mode != 0) d++;
    end
    exp_err = (exp_err + d > 65535) ? 65535 : exp_err + d;
    chk("err_cnt", err_cnt, exp_err);
    tick;
    chk("done_one_cycle", done, 0);
    chk("idle_not_busy", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          cyc, n;
    logic [31:0] a, sd;
    logic [7:0]  ln;
    logic [1:0]  bt;
    knobs_default();
    ARESET = 1; start = 0; cfg_addr = '0; cfg_len = '0; cfg_burst = '0; cfg_seed = '0;
    repeat (3) tick;
    ARESET = 0;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);

    run_pass(32'h1000, 8'd3, 2'd1, 32'hACE1);

    k_aw_wait = 5;
    run_pass(32'h1400, 8'd2, 2'd1, 32'h1234_5678);
    chk("aw_valid_cycles", aw_vcyc, 6);

    run_pass(32'h1800, 8'd2, 2'd2, 32'h55);

    k_bad_beat = 1; k_bad_kind = 0; k_bresp = 2'd2;
    run_pass(32'h2000, 8'd3, 2'd1, 32'hBEEF);
    knobs_default();

    run_pass(32'h2400, 8'(MAX_LEN - 1), 2'd1, 32'h0);
    run_pass(32'h2800, 8'(MAX_LEN), 2'd1, 32'h9);
    run_pass(32'h2C02, 8'd1, 2'd1, 32'h9);
    run_pass(32'h3000, 8'd15, 2'd2, 32'hF00D);
    run_pass(32'h3100, 8'd0, 2'd0, 32'hFFFF_FFFF);
    k_bad_beat = 2; k_bad_kind = 3;
    run_pass(32'h3200, 8'd4, 2'd1, 32'h77);
    knobs_default();

    for (int t = 0; t < 40; t++) begin
      knobs_default();
      k_rand_stall = 1;
      k_aw_wait = $urandom_range(0, 3);
      a  = $urandom;
      if ($urandom % 4 != 0) a = a & ~32'(DATA_W / 8 - 1);
      ln = 8'($urandom_range(0, MAX_LEN));
      bt = 2'($urandom_range(0, 2));
      sd = ($urandom % 8 == 0) ? 32'h0 : $urandom;
      if ($urandom % 3 == 0) begin
        k_bad_beat = $urandom_range(0, int'(ln));
        k_bad_kind = $urandom_range(0, 3);
      end
      if ($urandom % 3 == 0) k_bresp = 2'($urandom_range(1, 3));
      k_bid_bad = ($urandom % 6 == 0);
      k_last_mode = $urandom_range(0, 4);
      if (k_last_mode > 2) k_last_mode = 0;
      if (k_last_mode == 1) begin
        if (ln == 0) k_last_mode = 2;
        else k_early = $urandom_range(0, int'(ln) - 1);
      end
      run_pass(a, ln, bt, sd);
    end
    knobs_default();

    clear_obs();
    cfg_addr = 32'h4000; cfg_len = 8'd7; cfg_burst = 2'd1; cfg_seed = 32'h1357;
    start = 1; tick; start = 0;
    cyc = 0;
    while (!(m_wvalid && wq.size() >= 2) && cyc < 200) begin tick; cyc++; end
    chk("reached_w_beat2", m_wvalid, 1);
    ARESET = 1;
    tick;
    chk("arst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err_cnt, 0);
    tick;
    ARESET = 0;
    exp_err = 0;
    n = wq.size();
    repeat (5) tick;
    chk("arst_no_more_beats", wq.size(), n);
    chk("arst_stays_idle", busy, 0);

`ifdef AXI_TG_TIMEOUT_EN
    clear_obs();
    k_no_b = 1;
    cfg_addr = 32'h5000; cfg_len = 8'd1; cfg_burst = 2'd1; cfg_seed = 32'h42;
    start = 1; tick; start = 0;
    cyc = 0;
    while (!done && cyc < 500) begin tick; cyc++; end
    chk("to_done", done, 1);
    chk("to_bready_cycles", bready_cyc, TO_CYC);
    chk("to_no_ar", ar_hs, 0);
    exp_err = exp_err + 1;
    chk("to_err", err_cnt, exp_err);
    tick;
    chk("to_valids_dropped", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    knobs_default();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_master_traffic_gen.md
AXI_MASTER_TRAFFIC_GEN -- requirements
Module: axi_master_traffic_gen

Interface
REQ-001 Parameter ADDR_W, default 32, AXI address width.
REQ-002 Parameter DATA_W, default 32, data width; legal values 32, 64, 128.
REQ-003 Parameter ID_W, default 4, AXI ID width.
REQ-004 Parameter MASTER_ID, default 0, value driven on AWID/ARID.
REQ-005 Parameter MAX_LEN, default 16, maximum beats per burst (1..256).
REQ-006 Parameter TO_CYCLES, default 1024, watchdog limit (used only with the Configuration macro).
REQ-007 Port ACLK, input, 1, single clock; all logic on its rising edge.
REQ-008 Port ARESET, input, 1, synchronous active-high reset.
REQ-009 Port start, input, 1, one-cycle pulse that launches a write-burst/read-burst/verify pass; ignored while busy.
REQ-010 Port cfg_addr, input, ADDR_W, burst start address, sampled on start.
REQ-011 Port cfg_len, input, 8, AxLEN value (beats-1), sampled on start.
REQ-012 Port cfg_burst, input, 2, AxBURST (FIXED/INCR/WRAP), sampled on start.
REQ-013 Port cfg_seed, input, 32, data-pattern seed; 0 is replaced by 32'h1, sampled on start.
REQ-014 Port busy, output, 1, high from the cycle after start until done.
REQ-015 Port done, output, 1, one-cycle pulse at pass end.
REQ-016 Port err_cnt, output, 16, saturating count of errors since reset.
REQ-017 Ports m_aw{id,addr,len,size,burst,valid} out, m_awready in: AXI4 write-address channel.
REQ-018 Ports m_w{data,strb,last,valid} out, m_wready in: write-data channel.
REQ-019 Ports m_b{id,resp,valid} in, m_bready out: write-response channel.
REQ-020 Ports m_ar{id,addr,len,size,burst,valid} out, m_arready in: read-address channel.
REQ-021 Ports m_r{id,data,resp,last,valid} in, m_rready out: read-data channel.

Function
REQ-022 FSM states are IDLE, AW, W, B, AR, R, DONE; start in IDLE moves to AW, or to DONE with err_cnt+1 when the config is illegal.
REQ-023 Illegal config: WRAP with cfg_len not in {1,3,7,15}; cfg_len+1 > MAX_LEN; cfg_addr not aligned to DATA_W/8.
REQ-024 AxSIZE = log2(DATA_W/8); wstrb is all ones.
REQ-025 Every VALID, once high, stays high with stable payload until its READY is sampled high; a transfer completes in the cycle where both are high.
REQ-026 AW leads to W on handshake; W beats are issued back-to-back, one per handshake cycle; wlast is high only on beat cfg_len; the wlast handshake leads to B.
REQ-027 m_bready is high only in state B; bvalid leads to AR; bresp != OKAY or bid != MASTER_ID adds 1 to err_cnt.
REQ-028 AR leads to R on handshake; m_rready is high throughout R.
REQ-029 Write beat i carries the i-th output of a 32-bit Galois LFSR (taps 32,22,2,1) seeded by cfg_seed, replicated across DATA_W.
REQ-030 A second LFSR instance regenerates the sequence during R; each beat with rdata mismatch, rresp != OKAY, or rid mismatch adds 1 to err_cnt (one increment per beat at most).
REQ-031 rlast on beat < cfg_len, or no rlast on beat cfg_len, adds 1 to err_cnt and moves R to DONE after that beat.
REQ-032 DONE lasts one cycle with done=1, then IDLE; busy=0 in IDLE.
REQ-033 err_cnt saturates at 16'hFFFF.

Reset
REQ-034 ARESET high forces, on the next edge and in any state: FSM to IDLE; every VALID/READY, busy, done to 0; err_cnt to 0; LFSRs to 32'h1.
REQ-035 Reset mid-burst abandons the transaction; no further beats are issued.

Configuration
REQ-036 Macro AXI_TG_TIMEOUT_EN compiled in: a per-state counter aborts to DONE with err_cnt+1 when a state is held TO_CYCLES cycles, dropping VALID/READY on abort; compiled out: no counter exists and states wait indefinitely.

Structure
REQ-037 axi_pkg holds the burst-type enum (FIXED/INCR/WRAP), the resp codes (OKAY/EXOKAY/SLVERR/DECERR), and the FSM state typedef.
REQ-038 The LFSR is a sub-module named axi_tg_lfsr (seed load, advance enable), instantiated twice.

Verification
REQ-039 Zero-wait slave; start with addr 0x1000, len 3, INCR, seed 0xACE1 -> 4 W beats, wlast on beat 3, readback matches, done pulse, err_cnt = 0.
REQ-040 Slave holds awready low for 5 cycles -> awvalid and awaddr stable for all 6 cycles, single AW handshake.
REQ-041 WRAP with len 2 -> no bus activity, done within 2 cycles, err_cnt = 1.
REQ-042 Slave corrupts read beat 1 and returns bresp = SLVERR -> err_cnt = 2 after done.
REQ-043 ARESET asserted during W beat 2 -> all valids 0 the next cycle, FSM in IDLE, err_cnt = 0.
REQ-044 With AXI_TG_TIMEOUT_EN and TO_CYCLES = 64, slave never asserts bvalid -> abort after 64 cycles in B, done pulse, err_cnt = 1.
